bullet_unit: RTL and testbench

BULLET_UNIT -- requirements
Module: bullet_unit

---
 rtl/bullet_pkg.sv | 13 +
 rtl/bullet_hit.sv | 20 ++
 rtl/bullet_unit.sv | 126 ++++++++++++
 tb/tb_bullet_unit.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/bullet_pkg.sv
// Shared types and default geometry for the bullet sprite.
package bullet_pkg;

  typedef enum logic {
    IDLE,
    MOVING
  } state_e;

  localparam int unsigned DefBulletW = 2;
  localparam int unsigned DefBulletH = 8;
  localparam logic [3:0]  DefColor   = 4'hF;

endpackage

// File: rtl/bullet_hit.sv
// Signed half-open range test: hit = pos in [lo, lo + SIZE).
module bullet_hit #(
  parameter int unsigned SIZE = 2
) (
  input  logic signed [15:0] pos,
  input  logic signed [15:0] lo,
  output logic               hit
);

  // One extra bit keeps lo + SIZE from wrapping near the top of the signed range.
  logic signed [16:0] pos_ext;
  logic signed [16:0] lo_ext;
  logic signed [16:0] hi_ext;

  assign pos_ext = {pos[15], pos};
  assign lo_ext  = {lo[15], lo};
  assign hi_ext  = lo_ext + $signed(17'(SIZE));
  assign hit     = (pos_ext >= lo_ext) && (pos_ext < hi_ext);

endmodule

// File: rtl/bullet_unit.sv
// Single-bullet sprite: launch from the ship, climb each frame, retire off the top.
// Define BULLET_AUTOFIRE_EN to treat a held fire level as a request; otherwise a frame-sampled rising edge is needed.
module bullet_unit
  import bullet_pkg::*;
#(
  parameter int unsigned BULLET_W = DefBulletW,
  parameter int unsigned BULLET_H = DefBulletH,
  parameter logic [3:0]  COLOR    = DefColor
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               fire,
  input  logic               frame,
  input  logic               screen_line,
  input  logic        [7:0]  speed,
  input  logic signed [15:0] screen_x,
  input  logic signed [15:0] screen_y,
  input  logic signed [15:0] spaceship_x,
  input  logic signed [15:0] spaceship_y,
  output logic               drawing,
  output logic        [3:0]  pixel
);

  state_e             state_q, state_d;
  logic signed [15:0] bullet_x_q, bullet_x_d;
  logic signed [15:0] bullet_y_q, bullet_y_d;
  logic               row_hit_q;
  logic               drawing_q;
  logic               fire_valid;
  logic               row_in, col_in;

  logic signed [15:0] y_moved;
  logic signed [15:0] y_bottom;
  logic signed [15:0] launch_y;
  logic               retire;

  assign y_moved  = bullet_y_q - $signed({8'h00, speed});
  assign y_bottom = y_moved + $signed(16'(BULLET_H));
  assign retire   = (y_bottom <= 16'sd0);
  assign launch_y = spaceship_y - $signed(16'(BULLET_H));

`ifdef BULLET_AUTOFIRE_EN
  assign fire_valid = fire;
`else
  logic fire_prev_q;

  assign fire_valid = fire & ~fire_prev_q;

  // History advances on every frame strobe, so a level held across retirement never re-arms.
  always_ff @(posedge clk) begin
    if (rst) begin
      fire_prev_q <= 1'b0;
    end else if (frame) begin
      fire_prev_q <= fire;
    end
  end
`endif

  always_comb begin
    state_d    = state_q;
    bullet_x_d = bullet_x_q;
    bullet_y_d = bullet_y_q;
    if (frame) begin
      unique case (state_q)
        IDLE: begin
          if (fire_valid) begin
            bullet_x_d = spaceship_x;
            bullet_y_d = launch_y;
            state_d    = MOVING;
          end
        end
        MOVING: begin
          bullet_y_d = y_moved;
          if (retire) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      bullet_x_q <= '0;
      bullet_y_q <= '0;
    end else begin
      state_q    <= state_d;
      bullet_x_q <= bullet_x_d;
      bullet_y_q <= bullet_y_d;
    end
  end

  bullet_hit #(
    .SIZE(BULLET_H)
  ) u_row_hit (
    .pos(screen_y),
    .lo (bullet_y_q),
    .hit(row_in)
  );

  bullet_hit #(
    .SIZE(BULLET_W)
  ) u_col_hit (
    .pos(screen_x),
    .lo (bullet_x_q),
    .hit(col_in)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      row_hit_q <= 1'b0;
      drawing_q <= 1'b0;
    end else begin
      if (screen_line) begin
        row_hit_q <= (state_q == MOVING) && row_in;
      end
      drawing_q <= row_hit_q && col_in;
    end
  end

  assign drawing = drawing_q;
  assign pixel   = drawing_q ? COLOR : 4'h0;

endmodule

// File: tb/tb_bullet_unit.sv
// Directed bench for bullet_unit in the default (edge-triggered fire) build.
module tb_bullet_unit;
  import bullet_pkg::*;

  logic               clk = 1'b0;
  logic               rst;
  logic               fire;
  logic               frame;
  logic               screen_line;
  logic        [7:0]  speed;
  logic signed [15:0] screen_x;
  logic signed [15:0] screen_y;
  logic signed [15:0] spaceship_x;
  logic signed [15:0] spaceship_y;
  logic               drawing;
  logic        [3:0]  pixel;

  int n_checks = 0;
  int n_fail   = 0;

  bullet_unit dut (
    .clk        (clk),
    .rst        (rst),
    .fire       (fire),
    .frame      (frame),
    .screen_line(screen_line),
    .speed      (speed),
    .screen_x   (screen_x),
    .screen_y   (screen_y),
    .spaceship_x(spaceship_x),
    .spaceship_y(spaceship_y),
    .drawing    (drawing),
    .pixel      (pixel)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, $signed(obs), obs,
             $signed(exp), exp);
    end
  endtask

  task automatic do_frame(input logic f);
    fire  = f;
    frame = 1'b1;
    tick();
    frame = 1'b0;
  endtask

  task automatic latch_line(input logic signed [15:0] y);
    screen_y    = y;
    screen_line = 1'b1;
    tick();
    screen_line = 1'b0;
  endtask

  task automatic probe_x(input string tag, input logic signed [15:0] x, input logic exp);
    screen_x = x;
    tick();
    check({tag, "_drawing"}, 16'(drawing), 16'(exp));
    check({tag, "_pixel"}, 16'(pixel), exp ? 16'h000F : 16'h0000);
  endtask

  initial begin
    rst = 1'b1; fire = 1'b0; frame = 1'b0; screen_line = 1'b0; speed = 8'd0;
    screen_x = '0; screen_y = '0; spaceship_x = '0; spaceship_y = '0;

    // Reset held two clocks
    tick();
    tick();
    check("rst_state", 16'(dut.state_q), 16'(IDLE));
    check("rst_drawing", 16'(drawing), 16'h0);
    check("rst_pixel", 16'(pixel), 16'h0);
    check("rst_bullet_y", dut.bullet_y_q, 16'h0);
    rst = 1'b0;
    tick();

    // Launch from (100,200), speed 1
    spaceship_x = 16'sd100; spaceship_y = 16'sd200; speed = 8'd1;
    do_frame(1'b1);
    fire = 1'b0;
    check("launch_state", 16'(dut.state_q), 16'(MOVING));
    check("launch_y", dut.bullet_y_q, 16'sd192);
    check("launch_x", dut.bullet_x_q, 16'sd100);

    // Raster hits around (100,192), 2x8
    latch_line(16'sd195);
    probe_x("hit_x100", 16'sd100, 1'b1);
    probe_x("hit_x101", 16'sd101, 1'b1);
    probe_x("miss_x102", 16'sd102, 1'b0);
    probe_x("miss_x99", 16'sd99, 1'b0);
    latch_line(16'sd200);
    probe_x("miss_row200", 16'sd100, 1'b0);
    latch_line(16'sd192);
    probe_x("hit_row192", 16'sd100, 1'b1);
    latch_line(16'sd191);
    probe_x("miss_row191", 16'sd100, 1'b0);

    // Ten more frames; ship moves (ignored), last frame fires while moving (ignored)
    spaceship_x = 16'sd300; spaceship_y = 16'sd50;
    for (int i = 0; i < 9; i++) do_frame(1'b0);
    do_frame(1'b1);
    fire = 1'b0;
    check("fly_y", dut.bullet_y_q, 16'sd182);
    check("fly_x", dut.bullet_x_q, 16'sd100);
    check("fly_state", 16'(dut.state_q), 16'(MOVING));

    // Reset mid-flight with simultaneous frame and fire
    latch_line(16'sd185);
    probe_x("pre_rst_hit", 16'sd100, 1'b1);
    rst = 1'b1; fire = 1'b1; frame = 1'b1;
    tick();
    rst = 1'b0; fire = 1'b0; frame = 1'b0;
    check("midrst_state", 16'(dut.state_q), 16'(IDLE));
    check("midrst_drawing", 16'(drawing), 16'h0);
    check("midrst_y", dut.bullet_y_q, 16'h0);

    // Launch at y=2, speed 4, retire at -10
    spaceship_x = 16'sd40; spaceship_y = 16'sd10; speed = 8'd4;
    do_frame(1'b1);
    check("l2_y", dut.bullet_y_q, 16'sd2);
    do_frame(1'b0);
    check("l2_y_m2", dut.bullet_y_q, -16'sd2);
    do_frame(1'b0);
    check("l2_y_m6", dut.bullet_y_q, -16'sd6);
    check("l2_still_moving", 16'(dut.state_q), 16'(MOVING));
    do_frame(1'b1);  // rising fire on the retiring frame must not relaunch
    check("retire_y", dut.bullet_y_q, -16'sd10);
    check("retire_state", 16'(dut.state_q), 16'(IDLE));
    do_frame(1'b0);
    check("idle_stays", 16'(dut.state_q), 16'(IDLE));
    do_frame(1'b1);
    check("refire_state", 16'(dut.state_q), 16'(MOVING));
    check("refire_y", dut.bullet_y_q, 16'sd2);
    check("refire_x", dut.bullet_x_q, 16'sd40);

    // Fire held high across retirement: no relaunch until it falls and rises
    do_frame(1'b1);
    do_frame(1'b1);
    do_frame(1'b1);
    check("held_retire_state", 16'(dut.state_q), 16'(IDLE));
    do_frame(1'b1);
    check("held_no_relaunch", 16'(dut.state_q), 16'(IDLE));
    check("held_y_unchanged", dut.bullet_y_q, -16'sd10);
    do_frame(1'b0);
    do_frame(1'b1);
    check("edge_relaunch", 16'(dut.state_q), 16'(MOVING));
    check("edge_relaunch_y", dut.bullet_y_q, 16'sd2);

    // Speed 0: bullet parks
    speed = 8'd0;
    for (int i = 0; i < 5; i++) do_frame(1'b0);
    check("park_y", dut.bullet_y_q, 16'sd2);
    check("park_state", 16'(dut.state_q), 16'(MOVING));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
